lifo_arbiter: RTL
=================

// Module: lifo_arbiter
// PURPOSE
//  Shares one lifo stack instance between NREQ requesters, such as per-core fingerprint units.
//  Round-robin arbitration grants one push or pop per cycle.
//  It keeps its own occupancy count, rejects overflow and underflow with an error response,
//  captures pop data, and sequences a full drain (flush) of the stack.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  DEPTH  32  stack depth; must equal the attached lifo depth
//  WIDTH  32  data width
//  CNTW   6   occupancy counter width, >= log2(DEPTH+1)
// PORTS
//  clk             in   1           clock
//  reset           in   1           asynchronous, active-high
//  req             in   NREQ        per-requester request, held until gnt
//  req_pop         in   NREQ        per-requester op: 1 = pop, 0 = push
//  req_wdata       in   NREQ*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH]
//  gnt             out  NREQ        one-hot grant, combinational, same cycle as accept
//  rsp_valid       out  1           registered response strobe
//  rsp_id          out  NREQ        one-hot requester id of the response
//  rsp_err         out  1           1 = push while full or pop while empty; op not performed
//  rsp_rdata       out  WIDTH       popped word; 0 on push or error
//  flush           in   1           pulse: drain all entries
//  busy            out  1           flush in progress
//  count           out  CNTW        current occupancy
//  full            out  1           count == DEPTH
//  lifo_push       out  1           to lifo push
//  lifo_push_data  out  WIDTH       to lifo push_data
//  lifo_pop        out  1           to lifo pop
//  lifo_tos        in   WIDTH       from lifo tos (current top of stack)
//  lifo_empty_n    in   1           from lifo empty_n (informational only)
// BEHAVIOUR
//  Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_rdata=0, busy=0, count=0, full=0,
//   lifo_push=0, lifo_pop=0, rr pointer=0.
//  FSM states:
//   IDLE   arbitrate.
//   FLUSH  one lifo_pop per cycle while count>0; gnt forced to 0.
//   Transitions: IDLE->FLUSH on flush. FLUSH->IDLE in the cycle count reaches 0.
//   flush while count==0 is a one-cycle FLUSH visit.
//  Arbitration (IDLE only):
//   Requester priority starts at the rr pointer and rotates.
//   After each grant the rr pointer = granted index+1 (mod NREQ).
//   If no req is asserted, the pointer holds.
//  Grant of a push:
//   count<DEPTH: lifo_push=1 and lifo_push_data=req_wdata[id] in the same cycle; count+1.
//   count==DEPTH: no lifo strobe; rsp_err=1.
//  Grant of a pop:
//   count>0: rsp_rdata <= lifo_tos sampled in the grant cycle; lifo_pop=1; count-1.
//   count==0: no strobe; rsp_err=1.
//  lifo_tos must be sampled before the pop strobe takes effect.
//  lifo_push and lifo_pop are never asserted together.
//  Latency: rsp_valid/rsp_id/rsp_err/rsp_rdata are registered, 1 cycle after gnt.
//   rsp_valid is a single-cycle pulse per grant.
//  Back-to-back pop immediately after a push: returns the pushed word.
//   The lifo updates tos after its push edge.
//  flush in the same cycle as a req: flush wins, gnt=0, and the request stays pending.
//  flush while busy is ignored.
//  Flush pops produce no rsp_valid.
//  Reset mid-flush or mid-operation: state and count return to reset values.
//   The lifo shares reset, so its contents are discarded consistently.
//  count never wraps: saturation is guaranteed by the full/empty rejection rules.
//  full is combinational from count.
// STRUCTURE
//  Shared package lifo_pkg: FSM state encoding (ST_IDLE, ST_FLUSH) and OP_PUSH/OP_POP constants.
//  Sub-module rr_arbiter #(NREQ): inputs req, ptr; output one-hot gnt plus the encoded index.
//  The FSM, counter and response register live in lifo_arbiter.
//  The lifo is instantiated by the parent, not inside this block.
// TESTING (bench instantiates lifo_arbiter + lifo, DEPTH=4, NREQ=4)
//  1. r0 push 0xA, then r0 pop
//     -> rsp r0 err=0 rdata=0xA; count 1->0.
//  2. r0..r3 all request push continuously
//     -> grants r0,r1,r2,r3,r0...
//     -> 5th grant rsp_err=1, full=1, count=4.
//  3. Pop on an empty stack
//     -> rsp_err=1, rdata=0, no lifo_pop, count stays 0.
//  4. Push 1,2,3, then pop x3
//     -> rdata 3,2,1; push then immediate pop in the next cycle returns the pushed word.
//  5. count=3, flush pulse with r1 requesting
//     -> busy 3 cycles, 3 lifo_pops, no rsp.
//     -> then r1 is granted, count=0.
//  6. Assert reset during flush at count=2
//     -> all outputs at reset values next cycle, busy=0, count=0.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared definitions for the lifo arbiter: FSM state encoding, request opcodes
// and a small width helper used for requester-index buses.
package lifo_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   // Width of an index able to address n requesters (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lifo_arbiter_if.sv
// Requester-side bundle of the lifo arbiter: request/grant handshake plus the
// registered response channel.
interface lifo_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
);

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_pop;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]       gnt;
   logic                  rsp_valid;
   logic [NREQ-1:0]       rsp_id;
   logic                  rsp_err;
   logic [WIDTH-1:0]      rsp_rdata;

   modport master (
      output req, req_pop, req_wdata,
      input  gnt, rsp_valid, rsp_id, rsp_err, rsp_rdata
   );

   modport slave (
      input  req, req_pop, req_wdata,
      output gnt, rsp_valid, rsp_id, rsp_err, rsp_rdata
   );

endinterface

// File: rtl/lifo.sv
// Plain stack attached beside the arbiter; tos always shows the most recent
// unpopped word and updates on the edge after a push or pop.
module lifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_tos,
   output logic             o_empty_n
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW-1:0] FULL_C = PW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_sp;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_top_addr;

   assign w_wr_addr  = AW'(r_sp);
   assign w_top_addr = AW'(r_sp - 1'b1);

   // NOTE: the storage array is deliberately not reset; r_sp alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (i_push && (r_sp != FULL_C)) begin
         r_mem[w_wr_addr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp <= '0;
      end else if (i_push && (r_sp != FULL_C)) begin
         r_sp <= r_sp + 1'b1;
      end else if (i_pop && (r_sp != '0)) begin
         r_sp <= r_sp - 1'b1;
      end
   end

   assign o_tos     = (r_sp == '0) ? '0 : r_mem[w_top_addr];
   assign o_empty_n = (r_sp != '0);

endmodule

// File: rtl/lifo_arbiter_rr.sv
// Round-robin picker: scans requesters starting at i_ptr and returns the first
// asserted one as a one-hot grant plus its encoded index.
module rr_arbiter
   import lifo_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDXW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDXW-1:0] o_idx,
   output logic            o_valid
);

   localparam int SW = IDXW + 1;
   localparam logic [SW-1:0] NREQ_C = SW'(NREQ);

   logic [SW-1:0]   w_sum;
   logic [IDXW-1:0] w_j;

   always_comb begin
      // NOTE: every output and temporary gets a default first, so no path through the scan infers a latch.
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_sum   = '0;
      w_j     = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, i_ptr} + SW'(k);
         if (w_sum >= NREQ_C) begin
            w_sum = w_sum - NREQ_C;
         end
         w_j = w_sum[IDXW-1:0];
         if (!o_valid && i_req[w_j]) begin
            o_valid    = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
         end
      end
   end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one external lifo between NREQ requesters: round-robin push/pop grants,
// overflow/underflow rejection, registered responses and a sequenced flush.
module lifo_arbiter
   import lifo_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 32,
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic             clk,
   input  logic             reset,
   lifo_arbiter_if.slave    bus,
   input  logic             flush,
   output logic             busy,
   output logic [CNTW-1:0]  count,
   output logic             full,
   output logic             lifo_push,
   output logic [WIDTH-1:0] lifo_push_data,
   output logic             lifo_pop,
   input  logic [WIDTH-1:0] lifo_tos,
   input  logic             lifo_empty_n
);

   localparam int IDXW = idx_w(NREQ);
   localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

   logic [0:0]       r_state;
   logic [CNTW-1:0]  r_count;
   logic [IDXW-1:0]  r_ptr;
   logic             r_rsp_valid;
   logic [NREQ-1:0]  r_rsp_id;
   logic             r_rsp_err;
   logic [WIDTH-1:0] r_rsp_rdata;

   logic [NREQ-1:0]  w_arb_gnt;
   logic [IDXW-1:0]  w_arb_idx;
   logic             w_arb_valid;
   logic             w_idle;
   logic             w_grant;
   logic [NREQ-1:0]  w_gnt;
   logic             w_is_pop;
   logic             w_push_ok;
   logic             w_pop_ok;
   logic             w_err;
   logic             w_flush_pop;
   logic [0:0]       w_state_nxt;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   // A flush request outranks any requester; the loser keeps req high and is served after the drain.
   assign w_idle      = (r_state == ST_IDLE);
   assign w_grant     = w_idle && !flush && w_arb_valid;
   assign w_gnt       = w_grant ? w_arb_gnt : '0;
   assign w_is_pop    = (bus.req_pop[w_arb_idx] == OP_POP);
   assign w_push_ok   = w_grant && !w_is_pop && (r_count != DEPTH_C);
   assign w_pop_ok    = w_grant &&  w_is_pop && (r_count != '0);
   assign w_err       = w_grant && !w_push_ok && !w_pop_ok;
   assign w_flush_pop = !w_idle && (r_count != '0);

   assign bus.gnt        = w_gnt;
   assign lifo_push      = w_push_ok;
   assign lifo_push_data = w_push_ok ? bus.req_wdata[w_arb_idx*WIDTH +: WIDTH] : '0;
   assign lifo_pop       = w_pop_ok || w_flush_pop;

   assign busy  = !w_idle;
   assign count = r_count;
   assign full  = (r_count == DEPTH_C);

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;

   // FLUSH leaves in the cycle whose pop empties the stack (or at once if already empty).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (flush) w_state_nxt = ST_FLUSH;
         ST_FLUSH: if (r_count <= ONE_C) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_ptr       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (lifo_push) begin
            r_count <= r_count + 1'b1;
         end else if (lifo_pop) begin
            r_count <= r_count - 1'b1;
         end
         if (w_grant) begin
            r_ptr <= (w_arb_idx == LAST_IDX) ? '0 : w_arb_idx + 1'b1;
         end
         r_rsp_valid <= w_grant;
         r_rsp_id    <= w_gnt;
         r_rsp_err   <= w_err;
         r_rsp_rdata <= w_pop_ok ? lifo_tos : '0;
      end
   end

   // The lifo keeps its own fill level; it must always agree with our count.
   a_empty_track: assert property (@(posedge clk) disable iff (reset)
      (r_count != '0) == lifo_empty_n);

   a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
      !(lifo_push && lifo_pop));

endmodule
